rede_in_buf: RTL and testbench

//  Input staging buffer feeding the network processor's io_in/req_in port. Provides one FIFO per processor input channel.

---
 rtl/rede_io_pkg.sv | 12 +
 rtl/rede_in_buf_if.sv | 16 +
 rtl/rede_chan_fifo.sv | 68 ++++++
 rtl/rede_in_buf.sv | 89 ++++++++
 tb/tb_rede_in_buf.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rede_io_pkg.sv
// rtl/rede_io_pkg.sv - shared widths and types for the network processor input staging buffer
package rede_io_pkg;

    localparam int DEF_NUBITS = 31;
    localparam int DEF_NUIOIN = 4;
    localparam int DEF_DEPTH  = 8;
    localparam int CH_W       = $clog2(DEF_NUIOIN);

    typedef logic signed [DEF_NUBITS-1:0] sample_t;
    typedef logic        [CH_W-1:0]       chan_t;

endpackage

// File: rtl/rede_in_buf_if.sv
// rtl/rede_in_buf_if.sv - channel-tagged sample push bus into the input staging buffer
interface rede_in_buf_if #(
    parameter int NUBITS = rede_io_pkg::DEF_NUBITS,
    parameter int NUIOIN = rede_io_pkg::DEF_NUIOIN
);
    import rede_io_pkg::*;

    logic signed [NUBITS-1:0]         s_data;
    logic        [$clog2(NUIOIN)-1:0] s_chan;
    logic                             s_valid;
    logic                             s_ready;

    modport master (output s_data, output s_chan, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_chan, input  s_valid, output s_ready);

endinterface

// File: rtl/rede_chan_fifo.sv
// rtl/rede_chan_fifo.sv - one per-channel FIFO; RDE_HOLD_LAST_EN adds a last-popped register
module rede_chan_fifo
    import rede_io_pkg::*;
#(
    parameter int NUBITS = DEF_NUBITS,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic signed [NUBITS-1:0] din,
    output logic signed [NUBITS-1:0] dout,
    output logic                     empty,
    output logic                     full
`ifdef RDE_HOLD_LAST_EN
    ,
    output logic signed [NUBITS-1:0] last
`endif
);
    localparam int PW = $clog2(DEPTH);

    logic signed [NUBITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]            wr_q, rd_q;
    logic [PW:0]              cnt_q, cnt_d;
    logic                     do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    // Storage carries no reset: contents are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

`ifdef RDE_HOLD_LAST_EN
    logic signed [NUBITS-1:0] last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        last_q <= '0;
        else if (do_pop) last_q <= dout;
    end

    assign last = last_q;
`endif

endmodule

// File: rtl/rede_in_buf.sv
// rtl/rede_in_buf.sv - per-channel input FIFOs read by one-hot req_in; RDE_HOLD_LAST_EN replays last value on underrun
module rede_in_buf #(
    parameter int NUBITS = rede_io_pkg::DEF_NUBITS,
    parameter int NUIOIN = rede_io_pkg::DEF_NUIOIN,
    parameter int DEPTH  = rede_io_pkg::DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    rede_in_buf_if.slave             s,
    input  logic [NUIOIN-1:0]        req_in,
    output logic signed [NUBITS-1:0] io_in,
    output logic [NUIOIN-1:0]        empty,
    output logic [NUIOIN-1:0]        underrun,
    input  logic [NUIOIN-1:0]        clr_underrun,
    output logic                     req_err
);
    import rede_io_pkg::*;

    localparam int CW = $clog2(NUIOIN);

    logic [NUIOIN-1:0]        full, push_v, pop_v, sel;
    logic signed [NUBITS-1:0] head   [NUIOIN];
    logic signed [NUBITS-1:0] ur_val [NUIOIN];
    logic                     chan_ok, s_ready_c;
    logic                     req_onehot, req_multi;
    logic [NUIOIN-1:0]        underrun_q, underrun_d;
    logic                     req_err_q, req_err_d;

    assign chan_ok    = (32'(s.s_chan) < NUIOIN);
    assign req_onehot = (req_in != '0) && ((req_in & (req_in - 1'b1)) == '0);
    assign req_multi  = (req_in != '0) && !req_onehot;

    // Readiness comes from the registered count, so a same-cycle pop never frees a full channel.
    always_comb begin
        s_ready_c = 1'b0;
        if (chan_ok) s_ready_c = ~full[s.s_chan];
    end
    assign s.s_ready = s_ready_c;

    for (genvar k = 0; k < NUIOIN; k++) begin : g_ch
        assign push_v[k] = s.s_valid & s_ready_c & (s.s_chan == CW'(k));
        assign sel[k]    = req_onehot & req_in[k];
        assign pop_v[k]  = sel[k] & ~empty[k];

        rede_chan_fifo #(.NUBITS(NUBITS), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_v[k]),
            .pop   (pop_v[k]),
            .din   (s.s_data),
            .dout  (head[k]),
            .empty (empty[k]),
            .full  (full[k])
`ifdef RDE_HOLD_LAST_EN
            ,
            .last  (ur_val[k])
`endif
        );

`ifndef RDE_HOLD_LAST_EN
        assign ur_val[k] = '0;
`endif
    end

    always_comb begin
        io_in = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (sel[k]) io_in = empty[k] ? ur_val[k] : head[k];
        end
    end

    // A fresh underrun outranks a clear arriving in the same cycle.
    assign underrun_d = (underrun_q & ~clr_underrun) | (sel & empty);
    assign req_err_d  = req_err_q | req_multi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_q <= '0;
            req_err_q  <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
            req_err_q  <= req_err_d;
        end
    end

    assign underrun = underrun_q;
    assign req_err  = req_err_q;

endmodule

// File: tb/tb_rede_in_buf.sv
// tb/tb_rede_in_buf.sv - directed self-checking bench for rede_in_buf
module tb_rede_in_buf;
    import rede_io_pkg::*;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req_in, empty, underrun, clr;
    sample_t    io_in;
    logic       req_err;
    int         checks, failures;

    rede_in_buf_if bus ();

    rede_in_buf dut (
        .clk          (clk),
        .rst          (rst),
        .s            (bus),
        .req_in       (req_in),
        .io_in        (io_in),
        .empty        (empty),
        .underrun     (underrun),
        .clr_underrun (clr),
        .req_err      (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
        bus.s_chan  = '0;
        bus.s_data  = '0;
        req_in      = '0;
        clr         = '0;
    endtask

    task automatic push(input int ch, input int v);
        bus.s_chan  = 2'(ch);
        bus.s_data  = sample_t'(v);
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        tick();
        checks++; if (empty !== 4'hF) begin failures++; $display("FAIL reset_empty got=%h exp=f", empty); end
        checks++; if (underrun !== 4'h0) begin failures++; $display("FAIL reset_underrun got=%h exp=0", underrun); end
        checks++; if (req_err !== 1'b0) begin failures++; $display("FAIL reset_req_err got=%b exp=0", req_err); end
        checks++; if (io_in !== sample_t'(0)) begin failures++; $display("FAIL reset_io_in got=%0d exp=0", io_in); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fifo_order();
        int exp_v [3];
        exp_v[0] = 5; exp_v[1] = -7; exp_v[2] = 9;
        for (int i = 0; i < 3; i++) push(2, exp_v[i]);
        checks++; if (empty[2] !== 1'b0) begin failures++; $display("FAIL order_nonempty got=%b exp=0", empty[2]); end
        req_in = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (io_in !== sample_t'(exp_v[i])) begin failures++; $display("FAIL order_io_in[%0d] got=%0d exp=%0d", i, io_in, exp_v[i]); end
            tick();
        end
        req_in = '0;
        checks++; if (empty[2] !== 1'b1) begin failures++; $display("FAIL order_empty_after got=%b exp=1", empty[2]); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) push(0, 100 + i);
        bus.s_chan = 2'd0; #1;
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL full_ready_ch0 got=%b exp=0", bus.s_ready); end
        bus.s_chan = 2'd1; #1;
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL full_ready_ch1 got=%b exp=1", bus.s_ready); end
        bus.s_chan = 2'd0; bus.s_data = sample_t'(999); bus.s_valid = 1'b1; req_in = 4'b0001; #1;
        checks++; if (io_in !== sample_t'(100)) begin failures++; $display("FAIL full_pop_head got=%0d exp=100", io_in); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL full_no_passthru got=%b exp=0", bus.s_ready); end
        tick();
        bus.s_valid = 1'b0; req_in = '0; #1;
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b exp=1", bus.s_ready); end
        push(0, 108);
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL full_refull got=%b exp=0", bus.s_ready); end
        req_in = 4'b0001;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++; if (io_in !== sample_t'(101 + i)) begin failures++; $display("FAIL full_drain[%0d] got=%0d exp=%0d", i, io_in, 101 + i); end
            tick();
        end
        req_in = '0;
        checks++; if (empty[0] !== 1'b1) begin failures++; $display("FAIL full_drained got=%b exp=1", empty[0]); end
    endtask

    task automatic test_underrun();
        sample_t exp_ur;
`ifdef RDE_HOLD_LAST_EN
        exp_ur = sample_t'(108);
`else
        exp_ur = sample_t'(0);
`endif
        req_in = 4'b0001; #1;
        checks++; if (io_in !== exp_ur) begin failures++; $display("FAIL underrun_io_in got=%0d exp=%0d", io_in, exp_ur); end
        tick();
        checks++; if (underrun !== 4'b0001) begin failures++; $display("FAIL underrun_set got=%b exp=0001", underrun); end
        checks++; if (empty !== 4'hF) begin failures++; $display("FAIL underrun_no_pop got=%h exp=f", empty); end
        clr = 4'b0001;
        tick();
        checks++; if (underrun !== 4'b0001) begin failures++; $display("FAIL underrun_set_wins got=%b exp=0001", underrun); end
        req_in = '0;
        tick();
        clr = '0;
        checks++; if (underrun !== 4'b0000) begin failures++; $display("FAIL underrun_clear got=%b exp=0000", underrun); end
    endtask

    task automatic test_req_err();
        push(1, 42);
        req_in = 4'b0110; #1;
        checks++; if (io_in !== sample_t'(0)) begin failures++; $display("FAIL multihot_io_in got=%0d exp=0", io_in); end
        tick();
        req_in = '0;
        checks++; if (req_err !== 1'b1) begin failures++; $display("FAIL multihot_req_err got=%b exp=1", req_err); end
        checks++; if (empty !== 4'b1101) begin failures++; $display("FAIL multihot_no_pop got=%b exp=1101", empty); end
        checks++; if (underrun !== 4'b0000) begin failures++; $display("FAIL multihot_no_underrun got=%b exp=0000", underrun); end
        req_in = 4'b0010; #1;
        checks++; if (io_in !== sample_t'(42)) begin failures++; $display("FAIL multihot_then_read got=%0d exp=42", io_in); end
        tick();
        req_in = '0;
        checks++; if (empty !== 4'hF) begin failures++; $display("FAIL multihot_popped got=%h exp=f", empty); end
        checks++; if (req_err !== 1'b1) begin failures++; $display("FAIL req_err_sticky got=%b exp=1", req_err); end
    endtask

    task automatic test_wrap();
        int q[$];
        for (int c = 0; c < 3 * DEPTH + 3; c++) begin
            logic do_push, do_pop;
            do_push = (c < 3 * DEPTH);
            do_pop  = (c >= 3) && (q.size() > 0);
            bus.s_chan  = 2'd3;
            bus.s_data  = sample_t'(c);
            bus.s_valid = do_push;
            req_in      = do_pop ? 4'b1000 : 4'b0000;
            #1;
            if (do_push) begin
                checks++; if (bus.s_ready !== (q.size() < DEPTH)) begin failures++; $display("FAIL wrap_ready[%0d] got=%b exp=%b", c, bus.s_ready, q.size() < DEPTH); end
            end
            if (do_pop) begin
                checks++; if (io_in !== sample_t'(q[0])) begin failures++; $display("FAIL wrap_data[%0d] got=%0d exp=%0d", c, io_in, q[0]); end
            end
            tick();
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(c);
        end
        idle();
        checks++; if (empty !== 4'hF) begin failures++; $display("FAIL wrap_end_empty got=%h exp=f", empty); end
        checks++; if (underrun !== 4'h0) begin failures++; $display("FAIL wrap_no_underrun got=%h exp=0", underrun); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push(1, 200 + i);
        checks++; if (empty[1] !== 1'b0) begin failures++; $display("FAIL midrst_loaded got=%b exp=0", empty[1]); end
        #2 rst = 1'b0;
        #1;
        checks++; if (empty !== 4'hF) begin failures++; $display("FAIL midrst_empty_async got=%h exp=f", empty); end
        checks++; if (req_err !== 1'b0) begin failures++; $display("FAIL midrst_req_err got=%b exp=0", req_err); end
        tick();
        rst = 1'b1;
        bus.s_chan = 2'd1; #1;
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", bus.s_ready); end
        checks++; if (empty !== 4'hF) begin failures++; $display("FAIL midrst_still_empty got=%h exp=f", empty); end
        req_in = 4'b0010; #1;
        checks++; if (io_in !== sample_t'(0)) begin failures++; $display("FAIL midrst_ur_value got=%0d exp=0", io_in); end
        tick();
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fifo_order();
        test_full();
        test_underrun();
        test_req_err();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
